multicycle_decoder: RTL and testbench

Main control unit for the multicycle ARM datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states. Per cycle it drives the unconditioned control signals PCS, RegW, MemW and FlagW, which the conditional-logic stage gates with CondEx and the stored NZCV flags. It also drives the datapath mux selects and the ALU operation. Op, Funct and Rd come from the instruction register, which is loaded under IRWrite.

---
 rtl/multicycle_decoder.sv | 154 +++++++++++++++
 tb/tb_multicycle_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_decoder.sv
// Main control FSM for the multicycle ARM datapath: sequences each instruction
// and drives the write requests, mux selects and ALU operation per state.
module multicycle_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t     state_q;
  state_t     state_d;
  state_t     dec_state;
  logic       irwrite_s;
  logic       nextpc_s;
  logic       regw_s;
  logic       memw_s;
  logic       branch_s;
  logic       aluop_s;
  logic [1:0] alu_ctl;
  logic [1:0] flagw_s;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? EXECI : EXECR;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      EXECR:   state_d = ALUWB;
      EXECI:   state_d = ALUWB;
      default: state_d = FETCH;
    endcase
  end

  // While in reset the selects present the FETCH decode, whatever state was interrupted.
  assign dec_state = rst ? state_q : FETCH;

  always_comb begin
    irwrite_s = 1'b0;
    nextpc_s  = 1'b0;
    regw_s    = 1'b0;
    memw_s    = 1'b0;
    branch_s  = 1'b0;
    aluop_s   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    case (dec_state)
      FETCH: begin
        irwrite_s = 1'b1;
        nextpc_s  = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        regw_s    = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        memw_s = 1'b1;
      end
      EXECR:  aluop_s = 1'b1;
      EXECI: begin
        ALUSrcB = 2'b01;
        aluop_s = 1'b1;
      end
      ALUWB:  regw_s = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch_s  = 1'b1;
      end
      default: ;
    endcase
  end

  // Only ADD and SUB produce meaningful carry/overflow, so FlagW[0] is masked for logic ops.
  always_comb begin
    alu_ctl = 2'b00;
    flagw_s = 2'b00;
    if (aluop_s) begin
      case (Funct[4:1])
        4'b0100: alu_ctl = 2'b00;
        4'b0010: alu_ctl = 2'b01;
        4'b0000: alu_ctl = 2'b10;
        4'b1100: alu_ctl = 2'b11;
        default: alu_ctl = 2'b00;
      endcase
      flagw_s = {Funct[0], Funct[0] & ~alu_ctl[1]};
    end
  end

  assign ALUControl = alu_ctl;
  assign FlagW      = rst ? flagw_s : 2'b00;
  assign IRWrite    = rst & irwrite_s;
  assign NextPC     = rst & nextpc_s;
  assign RegW       = rst & regw_s;
  assign MemW       = rst & memw_s;
  assign PCS        = rst & (branch_s | (regw_s & (Rd == 4'd15)));
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};
  assign State      = state_q;

endmodule

// File: tb/tb_multicycle_decoder.sv
// Scoreboard bench for multicycle_decoder: each scenario queues the expected
// per-cycle state and outputs, then the DUT outputs are popped and compared.
module tb_multicycle_decoder;

  logic       clk;
  logic       rst;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] FlagW, ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       irw;
    logic       npc;
    logic       regw;
    logic       memw;
    logic       pcs;
    logic       adr;
    logic [1:0] rsrc;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluc;
    logic [1:0] flagw;
  } exp_t;

  exp_t sbq[$];

  multicycle_decoder dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Rd(Rd),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .FlagW(FlagW),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected Moore outputs for one state outside reset.
  function automatic exp_t row(input logic [3:0] st, input logic [1:0] aluc,
                               input logic [1:0] flagw, input logic rd15);
    exp_t e;
    e = '0;
    e.st = st;
    case (st)
      4'd0: begin e.irw = 1; e.npc = 1; e.srca = 1; e.srcb = 2'b10; e.rsrc = 2'b10; end
      4'd1: begin e.srca = 1; e.srcb = 2'b10; e.rsrc = 2'b10; end
      4'd2: e.srcb = 2'b01;
      4'd3: e.adr = 1;
      4'd4: begin e.rsrc = 2'b01; e.regw = 1; e.pcs = rd15; end
      4'd5: begin e.adr = 1; e.memw = 1; end
      4'd6: begin e.aluc = aluc; e.flagw = flagw; end
      4'd7: begin e.srcb = 2'b01; e.aluc = aluc; e.flagw = flagw; end
      4'd8: begin e.regw = 1; e.pcs = rd15; end
      4'd9: begin e.srcb = 2'b01; e.rsrc = 2'b10; e.pcs = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // Under reset: enables low, selects as in FETCH, State still the register value.
  function automatic exp_t reset_row(input logic [3:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    e.srca = 1;
    e.srcb = 2'b10;
    e.rsrc = 2'b10;
    return e;
  endfunction

  task automatic drain(input int n, input string name);
    exp_t e;
    exp_t a;
    logic [3:0] dec_exp;
    for (int i = 0; i < n; i++) begin
      #1;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL %s[%0d] scoreboard empty", name, i);
      end else begin
        e = sbq.pop_front();
        a.st = State; a.irw = IRWrite; a.npc = NextPC; a.regw = RegW; a.memw = MemW;
        a.pcs = PCS; a.adr = AdrSrc; a.rsrc = ResultSrc; a.srca = ALUSrcA;
        a.srcb = ALUSrcB; a.aluc = ALUControl; a.flagw = FlagW;
        if (a.st !== e.st) begin
          errors++;
          $display("FAIL %s[%0d] State got %0d want %0d", name, i, a.st, e.st);
        end
        checks++;
        if (a[14:0] !== e[14:0]) begin
          errors++;
          $display("FAIL %s[%0d] outputs irw npc regw memw pcs adr rsrc srca srcb aluc flagw got %b want %b",
                   name, i, a[14:0], e[14:0]);
        end
        dec_exp = {Op, (Op == 2'b01), (Op == 2'b10)};
        checks++;
        if ({ImmSrc, RegSrc} !== dec_exp) begin
          errors++;
          $display("FAIL %s[%0d] ImmSrc,RegSrc got %b want %b", name, i, {ImmSrc, RegSrc}, dec_exp);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
    Op = op; Funct = funct; Rd = rd;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_instr(2'b01, 6'b011001, 4'd15);
    repeat (2) @(posedge clk);
    @(negedge clk);
    sbq.push_back(reset_row(4'd0));
    drain(1, "reset");
    rst = 1'b1;
    #1;
    checks++;
    if ({IRWrite, NextPC, ALUSrcB} !== 4'b1110) begin
      errors++;
      $display("FAIL reset_release IRWrite,NextPC,ALUSrcB got %b want 1110", {IRWrite, NextPC, ALUSrcB});
    end
  endtask

  task automatic test_ldr(input logic [3:0] rd, input string name);
    set_instr(2'b01, 6'b011001, rd);
    sbq.push_back(row(4'd0, 2'b00, 2'b00, 1'b0));
    sbq.push_back(row(4'd1, 2'b00, 2'b00, 1'b0));
    sbq.push_back(row(4'd2, 2'b00, 2'b00, 1'b0));
    sbq.push_back(row(4'd3, 2'b00, 2'b00, 1'b0));
    sbq.push_back(row(4'd4, 2'b00, 2'b00, rd == 4'd15));
    drain(5, name);
  endtask

  task automatic test_str();
    set_instr(2'b01, 6'b011000, 4'd3);
    sbq.push_back(row(4'd0, 2'b00, 2'b00, 1'b0));
    sbq.push_back(row(4'd1, 2'b00, 2'b00, 1'b0));
    sbq.push_back(row(4'd2, 2'b00, 2'b00, 1'b0));
    sbq.push_back(row(4'd5, 2'b00, 2'b00, 1'b0));
    drain(4, "str");
  endtask

  task automatic test_dp(input logic [5:0] funct, input logic [3:0] rd, input logic [1:0] aluc,
                         input logic [1:0] flagw, input string name);
    set_instr(2'b00, funct, rd);
    sbq.push_back(row(4'd0, 2'b00, 2'b00, 1'b0));
    sbq.push_back(row(4'd1, 2'b00, 2'b00, 1'b0));
    sbq.push_back(row(funct[5] ? 4'd7 : 4'd6, aluc, flagw, 1'b0));
    sbq.push_back(row(4'd8, 2'b00, 2'b00, rd == 4'd15));
    drain(4, name);
  endtask

  task automatic test_branch_undef();
    set_instr(2'b10, 6'b000000, 4'd0);
    sbq.push_back(row(4'd0, 2'b00, 2'b00, 1'b0));
    sbq.push_back(row(4'd1, 2'b00, 2'b00, 1'b0));
    sbq.push_back(row(4'd9, 2'b00, 2'b00, 1'b0));
    drain(3, "branch");
    set_instr(2'b11, 6'b011001, 4'd15);
    sbq.push_back(row(4'd0, 2'b00, 2'b00, 1'b0));
    sbq.push_back(row(4'd1, 2'b00, 2'b00, 1'b0));
    drain(2, "undef");
  endtask

  task automatic test_abort();
    set_instr(2'b01, 6'b011001, 4'd15);
    sbq.push_back(row(4'd0, 2'b00, 2'b00, 1'b0));
    sbq.push_back(row(4'd1, 2'b00, 2'b00, 1'b0));
    drain(2, "abort_ldr");
    rst = 1'b0;
    sbq.push_back(reset_row(4'd2));
    sbq.push_back(reset_row(4'd0));
    drain(2, "abort_memadr");
    rst = 1'b1;
    set_instr(2'b01, 6'b011000, 4'd3);
    sbq.push_back(row(4'd0, 2'b00, 2'b00, 1'b0));
    sbq.push_back(row(4'd1, 2'b00, 2'b00, 1'b0));
    sbq.push_back(row(4'd2, 2'b00, 2'b00, 1'b0));
    drain(3, "abort_str");
    rst = 1'b0;
    sbq.push_back(reset_row(4'd5));
    sbq.push_back(reset_row(4'd0));
    drain(2, "abort_memwr");
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    Op = 2'b00; Funct = 6'b000000; Rd = 4'd0;
    test_reset();
    test_ldr(4'd3, "ldr");
    test_str();
    test_dp(6'b001001, 4'd15, 2'b00, 2'b11, "adds_pc");
    test_dp(6'b011000, 4'd2, 2'b11, 2'b00, "orr_reg");
    test_dp(6'b000101, 4'd4, 2'b01, 2'b11, "subs");
    test_dp(6'b000001, 4'd5, 2'b10, 2'b10, "ands");
    test_dp(6'b010101, 4'd6, 2'b00, 2'b11, "other_cmd");
    test_ldr(4'd15, "ldr_pc");
    test_branch_undef();
    test_abort();
    // back-to-back: the last instruction returns straight into FETCH
    set_instr(2'b10, 6'b000000, 4'd0);
    sbq.push_back(row(4'd0, 2'b00, 2'b00, 1'b0));
    drain(1, "final_fetch");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
